// File: rtl/fifo_ctrl_pkg.sv
// Shared widths and pointer type for the FIFO controller, its memory and the bench.
package fifo_ctrl_pkg;

  localparam int unsigned FIFO_DATA_W   = 8;
  localparam int unsigned FIFO_ADDR_W   = 3;
  localparam int unsigned FIFO_DEPTH    = 2 ** FIFO_ADDR_W;
  localparam int unsigned FIFO_AF_LEVEL = 6;

  typedef logic [FIFO_ADDR_W:0] ptr_t;

endpackage : fifo_ctrl_pkg

// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external dual-port memory: pointers, occupancy status,
// push/pop strobes and a valid qualifier for the registered read data.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = FIFO_DATA_W,
  parameter int unsigned ADDR_W   = FIFO_ADDR_W,
  parameter int unsigned AF_LEVEL = FIFO_AF_LEVEL
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr_w,
  output logic [ADDR_W-1:0] mem_addr_r,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              udf
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_afull;
  logic             r_out_valid;
  logic             r_ovf;
  logic             r_udf;

  logic             w_do_push;
  logic             w_do_pop;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [PTR_W-1:0] w_count_nxt;
  logic             w_full_nxt;

  // Requests are gated by the registered status, so read and write never share an address.
  always_comb begin
    w_do_push    = in_valid & ~r_full;
    w_do_pop     = pop & ~r_empty;
    w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_do_push);
    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_do_pop);
    w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    w_full_nxt   = (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]) &&
                   (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]);
  end

  // Pointers, status registered from next-pointer values, sticky error flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_afull     <= 1'b0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_full      <= w_full_nxt;
      r_empty     <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      r_afull     <= (w_count_nxt >= PTR_W'(AF_LEVEL));
      r_out_valid <= w_do_pop;
      if (in_valid && r_full) r_ovf <= 1'b1;
      if (pop && r_empty)     r_udf <= 1'b1;
    end
  end

  assign in_ready    = ~r_full;
  assign mem_write   = w_do_push;
  assign mem_read    = w_do_pop;
  assign mem_addr_w  = r_wr_ptr[ADDR_W-1:0];
  assign mem_addr_r  = r_rd_ptr[ADDR_W-1:0];
  assign mem_datain  = in_data;
  assign out_data    = mem_dataout;
  assign out_valid   = r_out_valid;
  assign full        = r_full;
  assign empty       = r_empty;
  assign almost_full = r_afull;
  assign count       = r_count;
  assign ovf         = r_ovf;
  assign udf         = r_udf;

endmodule : fifo_ctrl
